// File: rtl/uart_tx_9600_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_9600_pkg
//   Definitions shared by the UART transmit and receive paths: frame state
//   encodings, the default bit period for 9600 baud at 50 MHz, the data width
//   and the parity helper.
// ---------------------------------------------------------------------------
package uart_tx_9600_pkg;

   // 50_000_000 / 9600 clocks per bit
   localparam logic [12:0] DEFAULT_BPS_CNT = 13'd5208;
   localparam int          DATA_W          = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Even parity is the XOR of the data bits; odd parity is its complement.
   function automatic logic calc_parity(input logic [DATA_W-1:0] data,
                                        input logic              odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_9600_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Bit-period timer. Counts 0..BPS_CNT-1 while enabled and wraps; the count
//   is held at 0 whenever en=0, so every frame starts on a fresh period.
// Ports
//   clk    in   system clock
//   rst    in   synchronous, active-high reset
//   en     in   count enable
//   o_cnt  out  13-bit current count
//   o_tick out  high for the single clock where o_cnt == BPS_CNT-1
// ---------------------------------------------------------------------------
module uart_baud_tick
   import uart_tx_9600_pkg::*;
#(
   parameter logic [12:0] BPS_CNT = DEFAULT_BPS_CNT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [12:0] o_cnt,
   output logic        o_tick
);

   logic [12:0] r_cnt;
   logic        w_term;

   assign w_term = (r_cnt == (BPS_CNT - 13'd1));
   assign o_cnt  = r_cnt;
   assign o_tick = en & w_term;

   // Bit-period counter: clears when disabled, wraps at terminal count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 13'd0;
      end else if (!en) begin
         r_cnt <= 13'd0;
      end else if (w_term) begin
         r_cnt <= 13'd0;
      end else begin
         r_cnt <= r_cnt + 13'd1;
      end
   end

endmodule

// File: rtl/uart_tx_9600.sv
// ---------------------------------------------------------------------------
// uart_tx_9600
//   UART transmitter: 8 data bits LSB first, optional parity, 1 or 2 stop
//   bits. Bytes arrive over a valid/ready handshake; every output is a
//   register, so the next-cycle value of each output is computed from the
//   next state in the combinational process.
// Ports
//   clk      in   system clock (50 MHz by default)
//   rst      in   synchronous, active-high reset
//   tx_data  in   byte to send, captured on acceptance
//   tx_valid in   tx_data is valid
//   tx_ready out  a byte can be accepted this cycle
//   txd      out  serial line, idles high
//   tx_busy  out  frame in progress (start bit through last stop bit)
//   tx_done  out  one-clock pulse in the last clock of the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_9600
   import uart_tx_9600_pkg::*;
#(
   parameter logic [12:0] BPS_CNT    = DEFAULT_BPS_CNT,
   parameter logic        PARITY_EN  = 1'b0,
   parameter logic        PARITY_ODD = 1'b0,
   parameter logic [1:0]  STOP_BITS  = 2'd1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              txd,
   output logic              tx_busy,
   output logic              tx_done
);

   // Index of the final stop bit in the shared bit counter
   localparam logic [2:0] LAST_STOP = (STOP_BITS == 2'd2) ? 3'd1 : 3'd0;

   tx_state_e         r_state;
   tx_state_e         w_state_next;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_next;
   logic [2:0]        r_bit_cnt;
   logic [2:0]        w_bit_cnt_next;
   logic              r_par;
   logic              w_par_next;
   logic              w_txd_next;
   logic              w_done_next;
   logic [12:0]       w_cnt;
   logic              w_tick;
   logic              w_timer_en;
   logic              r_txd;
   logic              r_ready;
   logic              r_busy;
   logic              r_done;

   assign w_timer_en = (r_state != ST_IDLE);

   uart_baud_tick #(
      .BPS_CNT (BPS_CNT)
   ) u_baud_tick (
      .clk    (clk),
      .rst    (rst),
      .en     (w_timer_en),
      .o_cnt  (w_cnt),
      .o_tick (w_tick)
   );

   // Next-state, shift register, bit counter and next-output logic.
   always_comb begin
      w_state_next   = r_state;
      w_shift_next   = r_shift;
      w_bit_cnt_next = r_bit_cnt;
      w_par_next     = r_par;
      case (r_state)
         ST_IDLE: begin
            if (tx_valid && r_ready) begin
               w_state_next   = ST_START;
               w_shift_next   = tx_data;
               w_bit_cnt_next = 3'd0;
               w_par_next     = calc_parity(tx_data, PARITY_ODD);
            end else begin
               w_state_next   = ST_IDLE;
            end
         end
         ST_START: begin
            if (w_tick) begin
               w_state_next   = ST_DATA;
               w_bit_cnt_next = 3'd0;
            end else begin
               w_state_next   = ST_START;
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_bit_cnt == 3'd7) begin
                  w_state_next   = PARITY_EN ? ST_PARITY : ST_STOP;
                  w_bit_cnt_next = 3'd0;
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 3'd1;
                  w_shift_next   = {1'b0, r_shift[DATA_W-1:1]};
               end
            end else begin
               w_state_next = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (w_tick) begin
               w_state_next   = ST_STOP;
               w_bit_cnt_next = 3'd0;
            end else begin
               w_state_next   = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               if (r_bit_cnt == LAST_STOP) begin
                  w_state_next   = ST_IDLE;
                  w_bit_cnt_next = 3'd0;
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 3'd1;
               end
            end else begin
               w_state_next = ST_STOP;
            end
         end
         default: begin
            w_state_next   = ST_IDLE;
            w_bit_cnt_next = 3'd0;
         end
      endcase

      // Line level for the cycle after this edge follows the next state
      case (w_state_next)
         ST_IDLE:   w_txd_next = 1'b1;
         ST_START:  w_txd_next = 1'b0;
         ST_DATA:   w_txd_next = w_shift_next[0];
         ST_PARITY: w_txd_next = w_par_next;
         ST_STOP:   w_txd_next = 1'b1;
         default:   w_txd_next = 1'b1;
      endcase

      // One clock early: the pulse then lands in the last clock of the last stop bit
      if ((r_state == ST_STOP) && (r_bit_cnt == LAST_STOP) &&
          (w_cnt == (BPS_CNT - 13'd2))) begin
         w_done_next = 1'b1;
      end else begin
         w_done_next = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= 3'd0;
         r_par     <= 1'b0;
         r_txd     <= 1'b1;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_shift   <= w_shift_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_par     <= w_par_next;
         r_txd     <= w_txd_next;
         r_ready   <= (w_state_next == ST_IDLE);
         r_busy    <= (w_state_next != ST_IDLE);
         r_done    <= w_done_next;
      end
   end

   assign txd      = r_txd;
   assign tx_ready = r_ready;
   assign tx_busy  = r_busy;
   assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_9600.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_9600
//   Directed bench for uart_tx_9600 with a short bit period (10 clocks).
//   Three instances cover 8N1, 8E1 and 8O2; each expected frame is a
//   hand-computed line-bit vector (bit 0 = start bit, sent first).
// ---------------------------------------------------------------------------
module tb_uart_tx_9600;

   localparam int BPS = 10;

   logic       clk;
   logic [2:0] rst_v;
   logic [2:0] valid_v;
   logic [7:0] tx_data;
   logic [2:0] ready_v;
   logic [2:0] txd_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;

   int checks;
   int failures;

   uart_tx_9600 #(.BPS_CNT(13'd10), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2'd1)) u_8n1 (
      .clk(clk), .rst(rst_v[0]), .tx_data(tx_data), .tx_valid(valid_v[0]),
      .tx_ready(ready_v[0]), .txd(txd_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

   uart_tx_9600 #(.BPS_CNT(13'd10), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2'd1)) u_8e1 (
      .clk(clk), .rst(rst_v[1]), .tx_data(tx_data), .tx_valid(valid_v[1]),
      .tx_ready(ready_v[1]), .txd(txd_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

   uart_tx_9600 #(.BPS_CNT(13'd10), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2'd2)) u_8o2 (
      .clk(clk), .rst(rst_v[2]), .tx_data(tx_data), .tx_valid(valid_v[2]),
      .tx_ready(ready_v[2]), .txd(txd_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Sends one byte on instance sel and checks every clock of the frame.
   // Called at a negedge with the instance idle and ready. hold keeps
   // tx_valid high into the following idle cycle; noise toggles tx_valid and
   // drives tx_data=FF while busy; nxt is placed on tx_data at frame end.
   task automatic run_frame(input int sel, input logic [7:0] d, input logic [11:0] exp_bits,
                            input int nbits, input int exp_done, input logic hold,
                            input logic noise, input logic [7:0] nxt, input string tag);
      int len;
      int done_at;
      int done_cnt;
      len      = nbits * BPS;
      done_at  = -1;
      done_cnt = 0;
      tx_data      = d;
      valid_v[sel] = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         check_val({tag, "_txd"},   txd_v[sel],   exp_bits[(k-1)/BPS]);
         check_val({tag, "_ready"}, ready_v[sel], 1'b0);
         check_val({tag, "_busy"},  busy_v[sel],  1'b1);
         if (done_v[sel] === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         valid_v[sel] = (k == len) ? hold : (noise ? k[0] : hold);
         if (noise && (k < len)) tx_data = 8'hFF;
         if (k == len) tx_data = nxt;
      end
      check_val({tag, "_done_at"},  done_at,  exp_done);
      check_val({tag, "_done_cnt"}, done_cnt, 1);
      @(negedge clk);
      check_val({tag, "_idle_ready"}, ready_v[sel], 1'b1);
      check_val({tag, "_idle_busy"},  busy_v[sel],  1'b0);
      check_val({tag, "_idle_txd"},   txd_v[sel],   1'b1);
      check_val({tag, "_idle_done"},  done_v[sel],  1'b0);
   endtask

   initial begin
      int done_seen;
      checks   = 0;
      failures = 0;

      // 1. Reset with valid held high
      rst_v   = 3'b111;
      valid_v = 3'b111;
      tx_data = 8'h00;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check_val("rst_txd",   txd_v[i],   1'b1);
            check_val("rst_ready", ready_v[i], 1'b0);
            check_val("rst_busy",  busy_v[i],  1'b0);
            check_val("rst_done",  done_v[i],  1'b0);
         end
      end
      rst_v = 3'b000;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_val("rel_ready", ready_v[i], 1'b1);
         check_val("rel_txd",   txd_v[i],   1'b1);
         check_val("rel_busy",  busy_v[i],  1'b0);
      end
      valid_v = 3'b000;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_val("rel2_txd",  txd_v[i],  1'b1);
         check_val("rel2_busy", busy_v[i], 1'b0);
      end

      // 2. Single byte 55, 8N1
      run_frame(0, 8'h55, 12'h2AA, 10, 100, 1'b0, 1'b0, 8'h00, "b55");

      // 3. Back-to-back A3 then 0F with valid held
      run_frame(0, 8'hA3, 12'h346, 10, 100, 1'b1, 1'b0, 8'h0F, "bA3");
      run_frame(0, 8'h0F, 12'h21E, 10, 100, 1'b0, 1'b0, 8'h00, "b0F");

      // 4. Parity: 07 even (parity 1), 07 odd with two stop bits (parity 0)
      run_frame(1, 8'h07, 12'h60E, 11, 110, 1'b0, 1'b0, 8'h00, "e07");
      run_frame(2, 8'h07, 12'hC0E, 12, 120, 1'b0, 1'b0, 8'h00, "o07");

      // 5. Reset during D3 of 55 (D3 occupies clocks 41..50 after acceptance)
      done_seen  = 0;
      tx_data    = 8'h55;
      valid_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_v[0] = 1'b0;
      for (int k = 2; k <= 4*BPS + 3; k++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1) done_seen++;
      end
      check_val("mid_d3_txd", txd_v[0], 1'b0);
      rst_v[0] = 1'b1;
      @(negedge clk);
      check_val("mid_rst_txd",   txd_v[0],   1'b1);
      check_val("mid_rst_busy",  busy_v[0],  1'b0);
      check_val("mid_rst_ready", ready_v[0], 1'b0);
      if (done_v[0] === 1'b1) done_seen++;
      rst_v[0] = 1'b0;
      @(negedge clk);
      check_val("mid_rel_ready", ready_v[0], 1'b1);
      check_val("mid_rel_txd",   txd_v[0],   1'b1);
      if (done_v[0] === 1'b1) done_seen++;
      check_val("mid_no_done", done_seen, 0);
      run_frame(0, 8'h3C, 12'h278, 10, 100, 1'b0, 1'b0, 8'h00, "b3C");

      // 6. Busy protection: valid toggling and data=FF during frame of 5A
      run_frame(0, 8'h5A, 12'h2B4, 10, 100, 1'b0, 1'b1, 8'h00, "b5A");
      for (int c = 0; c < 2*BPS; c++) begin
         @(negedge clk);
         check_val("post_busy", busy_v[0], 1'b0);
         check_val("post_txd",  txd_v[0],  1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
